stepper_trajectory_sequencer: RTL

//  Trapezoidal move sequencer in front of the stepper PI position controller. Host loads target/vmax/accel over an

---
 rtl/stepper_trajectory_sequencer_if.sv | 22 ++
 rtl/stepper_trajectory_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_trajectory_sequencer_if.sv
// Host register bus plus the setpoint write port toward the position controller.
// The slave modport is the sequencer's view; the master modport is the host/controller view.
interface stepper_trajectory_sequencer_if;
  logic        write;
  logic [3:0]  address;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        m_write;
  logic [3:0]  m_address;
  logic [31:0] m_writedata;

  modport slave (
    input  write, address, writedata, read,
    output readdata, m_write, m_address, m_writedata
  );

  modport master (
    output write, address, writedata, read,
    input  readdata, m_write, m_address, m_writedata
  );
endinterface

// File: rtl/stepper_trajectory_sequencer.sv
// Trapezoidal move sequencer: streams ramped setpoints to the PI controller, one per update tick.
// Define SOFT_LIMIT_EN to add min/max position registers with target/preset clamping.
module stepper_trajectory_sequencer #(
  parameter int unsigned TICK_CYCLES   = 50_000,
  parameter logic [3:0]  ADDR_SETPOINT = 4'h0
) (
  input  logic clk,
  input  logic reset,
  stepper_trajectory_sequencer_if.slave bus,
  output logic busy,
  output logic done
);
  typedef enum logic [1:0] {ST_IDLE, ST_ACCEL, ST_CRUISE, ST_DECEL} state_t;

  localparam int unsigned   CW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);

  function automatic logic [31:0] sat32(input logic [32:0] x);
    return x[32] ? 32'hFFFF_FFFF : x[31:0];
  endfunction

  function automatic logic [31:0] umin32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

`ifdef SOFT_LIMIT_EN
  function automatic logic [31:0] clamp_pos(input logic signed [31:0] x, input logic signed [31:0] lo,
                                            input logic signed [31:0] hi);
    if (x < lo) return lo;
    else if (x > hi) return hi;
    else return x;
  endfunction
  logic [31:0] min_pos_r, max_pos_r;
`endif

  state_t      state_r, state_nx;
  logic [31:0] target_r, vmax_r, accel_r;
  logic [31:0] mv_target_r, mv_target_nx, mv_vmax_r, mv_vmax_nx, mv_accel_r, mv_accel_nx;
  logic [31:0] setpoint_r, setpoint_nx, v_r, v_nx, ramp_r, ramp_nx, wdata_r, wdata_nx;
  logic        err_r, err_nx, abort_r, abort_nx, lim_r, lim_nx;
  logic        m_write_r, m_write_nx, done_r, done_nx, busy_r;
  logic [CW-1:0] tick_cnt_r;
  logic        tick_s, ctrl_wr_s, start_s, abort_s, preset_wr_s, start_clamp_s, preset_clamp_s;
  logic [31:0] start_target_s, preset_val_s, acc_v_s, dec_v_s, vn_s, s_s, rd_s;
  logic [32:0] diff_s, rem_s;
  logic        dir_s, step_s, fin_s;

  assign tick_s      = (tick_cnt_r == TICK_LAST);
  assign ctrl_wr_s   = bus.write && (bus.address == 4'd3);
  assign abort_s     = ctrl_wr_s && bus.writedata[1];
  assign start_s     = ctrl_wr_s && bus.writedata[0] && !bus.writedata[1];
  assign preset_wr_s = bus.write && (bus.address == 4'd7);

`ifdef SOFT_LIMIT_EN
  assign start_target_s = clamp_pos(target_r, min_pos_r, max_pos_r);
  assign preset_val_s   = clamp_pos(bus.writedata, min_pos_r, max_pos_r);
`else
  assign start_target_s = target_r;
  assign preset_val_s   = bus.writedata;
`endif
  assign start_clamp_s  = (start_target_s != target_r);
  assign preset_clamp_s = (preset_val_s != bus.writedata);

  // Distance to go is taken at 33 bits so a full-range signed move cannot wrap.
  assign diff_s  = {mv_target_r[31], mv_target_r} - {setpoint_r[31], setpoint_r};
  assign dir_s   = diff_s[32];
  assign rem_s   = dir_s ? (33'd0 - diff_s) : diff_s;
  assign acc_v_s = umin32(sat32({1'b0, v_r} + {1'b0, mv_accel_r}), mv_vmax_r);
  assign dec_v_s = (v_r > mv_accel_r) ? (v_r - mv_accel_r) : 32'd1;

  // Host-writable configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_r  <= 32'd0;
      vmax_r    <= 32'd0;
      accel_r   <= 32'd0;
`ifdef SOFT_LIMIT_EN
      min_pos_r <= 32'h8000_0000;
      max_pos_r <= 32'h7FFF_FFFF;
`endif
    end else if (bus.write) begin
      case (bus.address)
        4'd0: target_r <= bus.writedata;
        4'd1: vmax_r   <= bus.writedata;
        4'd2: accel_r  <= bus.writedata;
`ifdef SOFT_LIMIT_EN
        4'd8: min_pos_r <= bus.writedata;
        4'd9: max_pos_r <= bus.writedata;
`endif
        default: begin end
      endcase
    end
  end

  // Free-running update tick divider.
  always_ff @(posedge clk) begin
    if (reset || tick_s) tick_cnt_r <= '0;
    else tick_cnt_r <= tick_cnt_r + CW'(1);
  end

  // Move sequencing: next state, profile arithmetic and setpoint step.
  always_comb begin
    state_nx     = state_r;
    setpoint_nx  = setpoint_r;
    v_nx         = v_r;
    ramp_nx      = ramp_r;
    mv_target_nx = mv_target_r;
    mv_vmax_nx   = mv_vmax_r;
    mv_accel_nx  = mv_accel_r;
    err_nx       = err_r;
    abort_nx     = abort_r;
    lim_nx       = lim_r;
    m_write_nx   = 1'b0;
    wdata_nx     = wdata_r;
    done_nx      = 1'b0;
    vn_s         = v_r;
    step_s       = 1'b0;
    s_s          = 32'd0;
    fin_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          if ((vmax_r == 32'd0) || (accel_r == 32'd0)) begin
            err_nx = 1'b1;
          end else begin
            err_nx       = 1'b0;
            lim_nx       = start_clamp_s;
            mv_target_nx = start_target_s;
            mv_vmax_nx   = vmax_r;
            mv_accel_nx  = accel_r;
            if (start_target_s == setpoint_r) begin
              done_nx = 1'b1;
            end else begin
              state_nx = ST_ACCEL;
              v_nx     = 32'd0;
              ramp_nx  = 32'd0;
              abort_nx = 1'b0;
            end
          end
        end else if (preset_wr_s) begin
          setpoint_nx = preset_val_s;
          lim_nx      = lim_r | preset_clamp_s;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ACCEL, ST_CRUISE, ST_DECEL: begin
        if (abort_s) begin
          state_nx = ST_DECEL;
          abort_nx = 1'b1;
        end else if (tick_s) begin
          case (state_r)
            ST_ACCEL: begin
              if (rem_s <= {1'b0, ramp_r}) begin
                state_nx = ST_DECEL;
              end else begin
                vn_s     = acc_v_s;
                step_s   = 1'b1;
                ramp_nx  = sat32({1'b0, ramp_r} + {1'b0, acc_v_s});
                state_nx = (acc_v_s == mv_vmax_r) ? ST_CRUISE : ST_ACCEL;
              end
            end
            ST_CRUISE: begin
              if (rem_s <= {1'b0, ramp_r}) state_nx = ST_DECEL;
              else step_s = 1'b1;
            end
            default: begin
              vn_s   = dec_v_s;
              step_s = 1'b1;
            end
          endcase
        end else begin
          state_nx = state_r;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // Step is capped at the remaining distance, so the target is never overshot.
    if (step_s) begin
      s_s         = ({1'b0, vn_s} <= rem_s) ? vn_s : rem_s[31:0];
      setpoint_nx = dir_s ? (setpoint_r - s_s) : (setpoint_r + s_s);
      v_nx        = vn_s;
      m_write_nx  = 1'b1;
      wdata_nx    = setpoint_nx;
      fin_s       = ({1'b0, s_s} == rem_s) ||
                    (abort_r && (state_r == ST_DECEL) && (vn_s <= mv_accel_r));
      if (fin_s) begin
        state_nx = ST_IDLE;
        v_nx     = 32'd0;
        done_nx  = 1'b1;
        abort_nx = 1'b0;
      end else begin
        done_nx = 1'b0;
      end
    end else begin
      fin_s = 1'b0;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      setpoint_r  <= 32'd0;
      v_r         <= 32'd0;
      ramp_r      <= 32'd0;
      mv_target_r <= 32'd0;
      mv_vmax_r   <= 32'd0;
      mv_accel_r  <= 32'd0;
      err_r       <= 1'b0;
      abort_r     <= 1'b0;
      lim_r       <= 1'b0;
      m_write_r   <= 1'b0;
      wdata_r     <= 32'd0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx;
      setpoint_r  <= setpoint_nx;
      v_r         <= v_nx;
      ramp_r      <= ramp_nx;
      mv_target_r <= mv_target_nx;
      mv_vmax_r   <= mv_vmax_nx;
      mv_accel_r  <= mv_accel_nx;
      err_r       <= err_nx;
      abort_r     <= abort_nx;
      lim_r       <= lim_nx;
      m_write_r   <= m_write_nx;
      wdata_r     <= wdata_nx;
      done_r      <= done_nx;
      busy_r      <= (state_nx != ST_IDLE);
    end
  end

  // Register read mux.
  always_comb begin
    rd_s = 32'd0;
    if (bus.read) begin
      case (bus.address)
        4'd0: rd_s = target_r;
        4'd1: rd_s = vmax_r;
        4'd2: rd_s = accel_r;
        4'd4: rd_s = {29'd0, lim_r, err_r, busy_r};
        4'd5: rd_s = setpoint_r;
        4'd6: rd_s = v_r;
`ifdef SOFT_LIMIT_EN
        4'd8: rd_s = min_pos_r;
        4'd9: rd_s = max_pos_r;
`endif
        default: rd_s = 32'd0;
      endcase
    end else begin
      rd_s = 32'd0;
    end
  end

  assign bus.readdata    = rd_s;
  assign bus.m_write     = m_write_r;
  assign bus.m_address   = ADDR_SETPOINT;
  assign bus.m_writedata = wdata_r;
  assign busy            = busy_r;
  assign done            = done_r;
endmodule
